// File: rtl/ntt_sequencer.sv
// Stage/address sequencer for the NTT core array: walks every stage of a forward or
// inverse transform, issuing one butterfly read per cycle and draining the core pipeline between stages.
module ntt_sequencer #(
    parameter int LOG_N          = 15,
    parameter int LOG_CORE_COUNT = 5,
    parameter int PIPE_LAT       = 8,
    parameter int ADDR_W         = LOG_N - LOG_CORE_COUNT - 1,
    parameter int STAGE_W        = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               inverse,
    output logic               busy,
    output logic               done,
    output logic [1:0]         mode,
    output logic [STAGE_W-1:0] log_m,
    output logic [STAGE_W-1:0] log_t,
    output logic [ADDR_W:0]    i,
    output logic [ADDR_W-1:0]  upper_read_address,
    output logic [ADDR_W-1:0]  lower_read_address,
    output logic               write_enable,
    output logic               stage_done
);

    localparam int DEPTH  = 1 << ADDR_W;
    localparam int DCNT_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

    localparam logic [STAGE_W-1:0] LAST_STAGE = STAGE_W'(LOG_N - 1);
    localparam logic [ADDR_W-1:0]  CNT_LAST   = ADDR_W'(DEPTH - 1);
    localparam logic [DCNT_W-1:0]  DCNT_LAST  = DCNT_W'(PIPE_LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic [DCNT_W-1:0]   dcnt_q, dcnt_d;
    logic                inv_q, inv_d;
    logic [STAGE_W-1:0]  log_m_q, log_m_d;
    logic [STAGE_W-1:0]  log_t_q, log_t_d;
    logic [1:0]          mode_q, mode_d;
    logic [ADDR_W:0]     i_q, i_d;
    logic [ADDR_W-1:0]   upper_q, upper_d;
    logic [ADDR_W-1:0]   lower_q, lower_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                stage_done_q, stage_done_d;
    logic [PIPE_LAT-1:0] pipe_q, pipe_d;
    logic                read_valid;
    logic                load_addr;
    int                  addr_sh;

    assign read_valid = (state_q == S_RUN);

    // Delay line models the core pipeline: a read issued now is written back PIPE_LAT cycles later.
    assign pipe_d[0] = read_valid;
    generate
        for (genvar gi = 1; gi < PIPE_LAT; gi++) begin : g_pipe
            assign pipe_d[gi] = pipe_q[gi-1];
        end
    endgenerate

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dcnt_d    = dcnt_q;
        inv_d     = inv_q;
        log_m_d   = log_m_q;
        log_t_d   = log_t_q;
        mode_d    = mode_q;
        i_d       = i_q;
        upper_d   = upper_q;
        lower_d   = lower_q;
        busy_d    = busy_q;
        load_addr = 1'b0;
        addr_sh   = 0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    inv_d     = inverse;
                    log_m_d   = inverse ? LAST_STAGE : '0;
                    log_t_d   = inverse ? '0 : LAST_STAGE;
                    mode_d    = inverse ? 2'd2 : 2'd1;
                    cnt_d     = '0;
                    busy_d    = 1'b1;
                    load_addr = 1'b1;
                    state_d   = S_RUN;
                end
            end
            S_RUN: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    dcnt_d  = '0;
                    state_d = S_DRAIN;
                end else begin
                    cnt_d     = cnt_q + ADDR_W'(1);
                    load_addr = 1'b1;
                end
            end
            S_DRAIN: begin
                if (dcnt_q == DCNT_LAST) begin
                    if (inv_q ? (log_m_q == '0) : (log_m_q == LAST_STAGE)) begin
                        busy_d  = 1'b0;
                        mode_d  = 2'd0;
                        log_m_d = '0;
                        log_t_d = '0;
                        i_d     = '0;
                        upper_d = '0;
                        lower_d = '0;
                        state_d = S_DONE;
                    end else begin
                        log_m_d   = inv_q ? (log_m_q - STAGE_W'(1)) : (log_m_q + STAGE_W'(1));
                        log_t_d   = LAST_STAGE - log_m_d;
                        load_addr = 1'b1;
                        state_d   = S_RUN;
                    end
                end else begin
                    dcnt_d = dcnt_q + DCNT_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Addresses follow the counter value that will be presented next cycle.
        if (load_addr) begin
            addr_sh = int'(log_t_d) - LOG_CORE_COUNT;
            upper_d = cnt_d;
            lower_d = (addr_sh > 0) ? (cnt_d ^ (ADDR_W'(1) << (addr_sh - 1))) : cnt_d;
            i_d     = (addr_sh >= 0) ? ({1'b0, cnt_d} >> addr_sh) : {1'b0, cnt_d};
        end

        stage_done_d = (state_d == S_DRAIN) && (dcnt_d == DCNT_LAST);
        done_d       = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            dcnt_q       <= '0;
            inv_q        <= 1'b0;
            log_m_q      <= '0;
            log_t_q      <= '0;
            mode_q       <= 2'd0;
            i_q          <= '0;
            upper_q      <= '0;
            lower_q      <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            stage_done_q <= 1'b0;
            pipe_q       <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            dcnt_q       <= dcnt_d;
            inv_q        <= inv_d;
            log_m_q      <= log_m_d;
            log_t_q      <= log_t_d;
            mode_q       <= mode_d;
            i_q          <= i_d;
            upper_q      <= upper_d;
            lower_q      <= lower_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            stage_done_q <= stage_done_d;
            pipe_q       <= pipe_d;
        end
    end

    assign busy               = busy_q;
    assign done               = done_q;
    assign mode               = mode_q;
    assign log_m              = log_m_q;
    assign log_t              = log_t_q;
    assign i                  = i_q;
    assign upper_read_address = upper_q;
    assign lower_read_address = lower_q;
    assign write_enable       = pipe_q[PIPE_LAT-1];
    assign stage_done         = stage_done_q;

endmodule

// File: tb/tb_ntt_sequencer.sv
// Bench for ntt_sequencer (LOG_N=8, 4 cores, PIPE_LAT=4): closed-form per-cycle output model
// plus a scoreboard of expected stage_done/done events queued when each start is driven.
module tb_ntt_sequencer;

    localparam int LOG_N   = 8;
    localparam int LCC     = 2;
    localparam int PL      = 4;
    localparam int AW      = LOG_N - LCC - 1;
    localparam int SW      = 4;
    localparam int DEPTH   = 1 << AW;
    localparam int SL      = DEPTH + PL;
    localparam int RUN_LEN = 1 + LOG_N * SL;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          inverse = 1'b0;
    logic          busy, done, write_enable, stage_done;
    logic [1:0]    mode;
    logic [SW-1:0] log_m, log_t;
    logic [AW:0]   i;
    logic [AW-1:0] upper_read_address, lower_read_address;

    ntt_sequencer #(
        .LOG_N(LOG_N), .LOG_CORE_COUNT(LCC), .PIPE_LAT(PL), .ADDR_W(AW), .STAGE_W(SW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .inverse(inverse),
        .busy(busy), .done(done), .mode(mode), .log_m(log_m), .log_t(log_t), .i(i),
        .upper_read_address(upper_read_address), .lower_read_address(lower_read_address),
        .write_enable(write_enable), .stage_done(stage_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int compared = 0;
    int mismatched = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Expected outputs t cycles after the cycle in which start was accepted.
    function automatic logic [29:0] expect_outs(input int t, input bit inv);
        int k, s, p, lm, lt, cnt, lo, iv;
        logic b, d, we, sd;
        logic [1:0] md;
        b = 0; d = 0; we = 0; sd = 0; md = 0;
        lm = 0; lt = 0; cnt = 0; lo = 0; iv = 0;
        if (t >= 1 && t <= LOG_N * SL) begin
            k   = t - 1;
            s   = k / SL;
            p   = k % SL;
            lm  = inv ? (LOG_N - 1 - s) : s;
            lt  = LOG_N - 1 - lm;
            cnt = (p < DEPTH) ? p : DEPTH - 1;
            lo  = (lt > LCC) ? (cnt ^ (1 << (lt - LCC - 1))) : cnt;
            iv  = (lt >= LCC) ? (cnt >> (lt - LCC)) : cnt;
            we  = (k >= PL) && (((k - PL) % SL) < DEPTH);
            sd  = (p == SL - 1);
            b   = 1;
            md  = inv ? 2'd2 : 2'd1;
        end else if (t == RUN_LEN) begin
            d = 1;
        end
        return {b, d, md, SW'(lm), SW'(lt), 6'(iv), 5'(cnt), 5'(lo), we, sd};
    endfunction

    logic [29:0] obs;
    assign obs = {busy, done, mode, log_m, log_t, i, upper_read_address,
                  lower_read_address, write_enable, stage_done};

    int model_c0 = -1;
    bit model_inv = 0;
    int we_cnt = 0;
    int done_q[$];
    int sd_cyc_q[$];
    int sd_lm_q[$];
    int mon_t;

    always @(negedge clk) begin
        mon_t = (model_c0 >= 0) ? (cyc - model_c0) : -1;
        check_eq("outputs", obs, expect_outs(mon_t, model_inv));
        if (write_enable) we_cnt++;
        if (stage_done) begin
            if (sd_cyc_q.size() == 0) begin
                check_eq("stage_done_unexpected", 1, 0);
            end else begin
                check_eq("stage_done_cycle", cyc, sd_cyc_q.pop_front());
                check_eq("stage_done_log_m", log_m, sd_lm_q.pop_front());
            end
        end
        if (done) begin
            if (done_q.size() == 0) begin
                check_eq("done_unexpected", 1, 0);
            end else begin
                check_eq("done_cycle", cyc, done_q.pop_front());
                check_eq("write_strobes", we_cnt, LOG_N * DEPTH);
                $display("transform done: t=%0d inverse=%0d writes=%0d", mon_t, model_inv, we_cnt);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic goto_cycle(input int target);
        while (cyc < target) step();
    endtask

    task automatic pulse_start(input bit inv, input bit accept);
        start   = 1'b1;
        inverse = inv;
        if (accept) begin
            model_c0  = cyc;
            model_inv = inv;
            we_cnt    = 0;
            done_q.push_back(cyc + RUN_LEN);
            for (int s = 0; s < LOG_N; s++) begin
                sd_cyc_q.push_back(cyc + (s + 1) * SL);
                sd_lm_q.push_back(inv ? (LOG_N - 1 - s) : s);
            end
        end
        step();
        start   = 1'b0;
        inverse = 1'b0;
    endtask

    int c0;

    initial begin
        repeat (3) step();
        check_eq("reset_outputs", obs, 0);
        rst_n = 1'b1;
        c0 = cyc;
        goto_cycle(c0 + 100);

        // Forward transform with explicit address spot checks
        c0 = cyc;
        pulse_start(1'b0, 1'b1);
        goto_cycle(c0 + 4);
        check_eq("no_early_write", write_enable, 0);
        step();
        check_eq("first_write", write_enable, 1);
        step();
        check_eq("upper_lt7_cnt5", upper_read_address, 5);
        check_eq("lower_lt7_cnt5", lower_read_address, 21);
        check_eq("i_lt7_cnt5", i, 0);
        goto_cycle(c0 + 190);
        check_eq("log_t_stage5", log_t, 2);
        check_eq("lower_lt2_cnt9", lower_read_address, 9);
        check_eq("i_lt2_cnt9", i, 9);
        goto_cycle(c0 + 300);

        // Inverse transform
        c0 = cyc;
        pulse_start(1'b1, 1'b1);
        goto_cycle(c0 + 2);
        check_eq("inverse_mode", mode, 2);
        check_eq("inverse_first_stage", log_m, LOG_N - 1);
        goto_cycle(c0 + 300);

        // Ignored start while busy, then asynchronous abort
        c0 = cyc;
        pulse_start(1'b0, 1'b1);
        goto_cycle(c0 + 50);
        pulse_start(1'b1, 1'b0);
        goto_cycle(c0 + 120);
        rst_n    = 1'b0;
        model_c0 = -1;
        done_q.delete();
        sd_cyc_q.delete();
        sd_lm_q.delete();
        #1;
        check_eq("async_reset_outputs", obs, 0);
        goto_cycle(c0 + 122);
        rst_n = 1'b1;
        goto_cycle(c0 + 130);

        // Fresh run after abort; start during DONE must be ignored
        c0 = cyc;
        pulse_start(1'b0, 1'b1);
        goto_cycle(c0 + RUN_LEN);
        check_eq("done_at_latency", done, 1);
        pulse_start(1'b0, 1'b0);
        goto_cycle(c0 + 330);

        check_eq("done_queue_drained", done_q.size(), 0);
        check_eq("stage_queue_drained", sd_cyc_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
